// File: rtl/io_display_pkg.sv
// Shared types and constants for the display controller: mode encoding,
// 640x480 VGA timing, image geometry and the image base addresses.
package io_display_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_PROC = 2'd1,
    SHOW_ORIG = 2'd2
  } disp_mode_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int IMG_W = 400;
  localparam int IMG_H = 400;
  localparam int X_OFF = 120;
  localparam int Y_OFF = 40;

  // Same byte addresses the I/O decoder carves out for the two image regions.
  localparam int PROC_BASE = 120;
  localparam int ORIG_BASE = 160120;

  localparam int ADDR_W = 24;
  localparam int CNT_W  = 10;

  // One pixel-tick pipeline stage of raster control signals.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic in_img;
  } pix_stage_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters and raw (undelayed) sync/visible/frame-boundary decode.
// Everything advances only on pix_en.
module vga_timing #(
  parameter int H_ACTIVE = io_display_pkg::H_ACTIVE,
  parameter int H_FP     = io_display_pkg::H_FP,
  parameter int H_SYNC   = io_display_pkg::H_SYNC,
  parameter int H_BP     = io_display_pkg::H_BP,
  parameter int V_ACTIVE = io_display_pkg::V_ACTIVE,
  parameter int V_FP     = io_display_pkg::V_FP,
  parameter int V_SYNC   = io_display_pkg::V_SYNC,
  parameter int V_BP     = io_display_pkg::V_BP
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_en,
  output logic [io_display_pkg::CNT_W-1:0] h_cnt,
  output logic [io_display_pkg::CNT_W-1:0] v_cnt,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             visible,
  output logic                             frame_end
);
  import io_display_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC - 1;

  logic h_last, v_last;

  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hsync     = !((h_cnt >= CNT_W'(HS_LO)) && (h_cnt <= CNT_W'(HS_HI)));
  assign vsync     = !((v_cnt >= CNT_W'(VS_LO)) && (v_cnt <= CNT_W'(VS_HI)));
  assign visible   = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign frame_end = h_last && v_last;

endmodule

// File: rtl/io_display_ctrl.sv
// Display controller: latches the image select written through the I/O
// decoder, swaps it in at frame boundaries and streams the image to VGA.
module io_display_ctrl #(
  parameter int H_ACTIVE  = io_display_pkg::H_ACTIVE,
  parameter int H_FP      = io_display_pkg::H_FP,
  parameter int H_SYNC    = io_display_pkg::H_SYNC,
  parameter int H_BP      = io_display_pkg::H_BP,
  parameter int V_ACTIVE  = io_display_pkg::V_ACTIVE,
  parameter int V_FP      = io_display_pkg::V_FP,
  parameter int V_SYNC    = io_display_pkg::V_SYNC,
  parameter int V_BP      = io_display_pkg::V_BP,
  parameter int IMG_W     = io_display_pkg::IMG_W,
  parameter int IMG_H     = io_display_pkg::IMG_H,
  parameter int X_OFF     = io_display_pkg::X_OFF,
  parameter int Y_OFF     = io_display_pkg::Y_OFF,
  parameter int PROC_BASE = io_display_pkg::PROC_BASE,
  parameter int ORIG_BASE = io_display_pkg::ORIG_BASE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_en,
  input  logic                              we,
  input  logic                              show_enb,
  input  logic                              show_original_enb,
  input  logic [7:0]                        wd,
  output logic [io_display_pkg::ADDR_W-1:0] rd_addr,
  input  logic [7:0]                        rd_data,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              blank_n,
  output logic [7:0]                        red,
  output logic [7:0]                        green,
  output logic [7:0]                        blue,
  output logic                              frame_start
);
  import io_display_pkg::*;

  localparam int X_END = X_OFF + IMG_W - 1;
  localparam int Y_END = Y_OFF + IMG_H - 1;

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic              hs_raw, vs_raw, visible, frame_end, in_img;
  disp_mode_t        mode, mode_nxt, pending, pending_nxt;
  logic [ADDR_W-1:0] addr_ptr;
  pix_stage_t        stg;
  logic              pix_on;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync     (hs_raw),
    .vsync     (vs_raw),
    .visible   (visible),
    .frame_end (frame_end)
  );

  assign in_img = (h_cnt >= CNT_W'(X_OFF)) && (h_cnt <= CNT_W'(X_END)) &&
                  (v_cnt >= CNT_W'(Y_OFF)) && (v_cnt <= CNT_W'(Y_END));

  function automatic logic [ADDR_W-1:0] mode_base(input disp_mode_t m);
    case (m)
      SHOW_PROC: mode_base = ADDR_W'(PROC_BASE);
      SHOW_ORIG: mode_base = ADDR_W'(ORIG_BASE);
      default:   mode_base = '0;
    endcase
  endfunction

  // Pending select follows CPU stores on any clk; the visible mode only
  // picks it up at the frame boundary so a frame is never torn.
  always_comb begin
    pending_nxt = pending;
    mode_nxt    = mode;
    if (we && show_enb)
      pending_nxt = (wd == 8'd0) ? IDLE : SHOW_PROC;
    else if (we && show_original_enb)
      pending_nxt = (wd == 8'd0) ? IDLE : SHOW_ORIG;
    if (pix_en && frame_end)
      mode_nxt = pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= IDLE;
      mode        <= IDLE;
      addr_ptr    <= '0;
      frame_start <= 1'b0;
      stg         <= '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, in_img: 1'b0};
    end else begin
      pending     <= pending_nxt;
      mode        <= mode_nxt;
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        stg <= '{hsync: hs_raw, vsync: vs_raw, blank_n: visible, in_img: in_img};
        // Raster order walks the image row-major, so a running pointer
        // replaces any row*width product.
        if (frame_end)
          addr_ptr <= mode_base(pending);
        else if (in_img && (mode != IDLE))
          addr_ptr <= addr_ptr + 1'b1;
      end
    end
  end

  assign rd_addr = addr_ptr;

  // rd_data arrives one pix tick after its address, aligned with stg.
  assign pix_on  = stg.in_img && (mode != IDLE);
  assign red     = pix_on ? rd_data : 8'd0;
  assign green   = pix_on ? rd_data : 8'd0;
  assign blue    = pix_on ? rd_data : 8'd0;
  assign hsync   = stg.hsync;
  assign vsync   = stg.vsync;
  assign blank_n = stg.blank_n;

endmodule

// File: tb/tb_io_display_ctrl.sv
// Directed bench for io_display_ctrl on a shrunken raster (24x17 total,
// 8x6 image at 4,3) so whole frames fit in a short run; bases unchanged.
module tb_io_display_ctrl;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;          // 408

  logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic        we = 1'b0, show_enb = 1'b0, show_original_enb = 1'b0;
  logic [7:0]  wd = 8'd0, rd_data = 8'd0;
  logic [23:0] rd_addr;
  logic        hsync, vsync, blank_n, frame_start;
  logic [7:0]  red, green, blue;

  int n_asserts = 0, n_fail = 0, ticks = 0;

  io_display_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(8), .IMG_H(6), .X_OFF(4), .Y_OFF(3),
    .PROC_BASE(120), .ORIG_BASE(160120)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .we(we), .show_enb(show_enb),
    .show_original_enb(show_original_enb), .wd(wd), .rd_addr(rd_addr),
    .rd_data(rd_data), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // pix_en is high on every other clk, changing away from the posedge.
  initial forever begin
    @(negedge clk);
    pix_en = ~pix_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one pix tick; the memory model returns addr[7:0] one tick late.
  task automatic pix();
    logic [23:0] a;
    a = rd_addr;
    @(posedge clk);
    while (!pix_en) begin
      a = rd_addr;
      @(posedge clk);
    end
    rd_data = a[7:0];
    ticks++;
    #1;
  endtask

  function automatic int hpos();
    return ticks % HT;
  endfunction

  function automatic int vpos();
    return (ticks / HT) % VT;
  endfunction

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    do begin
      pix();
      n++;
    end while (!(hpos() == h && vpos() == v) && n < 2 * FRAME);
    if (!(hpos() == h && vpos() == v)) begin
      n_asserts++;
      n_fail++;
      $error("FAIL run_to: position (%0d,%0d) never reached", h, v);
    end
  endtask

  // Called right after pix(), so the store lands on a non-pix clk.
  task automatic wr(input logic se, input logic soe, input logic [7:0] d);
    we = 1'b1; show_enb = se; show_original_enb = soe; wd = d;
    @(posedge clk);
    #1;
    we = 1'b0; show_enb = 1'b0; show_original_enb = 1'b0; wd = 8'd0;
  endtask

  initial begin
    int hs_lo, vs_lo, bl_hi, rgb_nz, fs_cnt;

    repeat (4) @(posedge clk);
    #1;
    chk("reset hsync", hsync, 1);
    chk("reset vsync", vsync, 1);
    chk("reset blank_n", blank_n, 0);
    chk("reset rgb", {red, green, blue}, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset frame_start", frame_start, 0);
    rst = 1'b0;
    ticks = 0;

    // 1: two idle frames
    hs_lo = 0; vs_lo = 0; bl_hi = 0; rgb_nz = 0; fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      pix();
      hs_lo  += int'(!hsync);
      vs_lo  += int'(!vsync);
      bl_hi  += int'(blank_n);
      rgb_nz += int'({red, green, blue} != 24'd0);
      fs_cnt += int'(frame_start);
    end
    chk("hsync low ticks", hs_lo, 2 * VT * HS);
    chk("vsync low ticks", vs_lo, 2 * HT * VS);
    chk("visible ticks", bl_hi, 2 * HA * VA);
    chk("idle rgb nonzero", rgb_nz, 0);
    chk("frame_start count", fs_cnt, 2);
    chk("frame_start at boundary", frame_start, 1);
    @(posedge clk);
    #1;
    chk("frame_start one clk", frame_start, 0);

    // 2: select processed mid-frame
    run_to(5, 4);
    wr(1'b1, 1'b0, 8'd1);
    run_to(6, 4);
    chk("same frame rd_addr", rd_addr, 0);
    chk("same frame rgb", red, 0);
    run_to(4, 3);
    chk("proc first addr", rd_addr, 120);
    run_to(5, 3);
    chk("proc second addr", rd_addr, 121);
    chk("proc first pixel", red, 8'h78);
    run_to(11, 3);
    chk("proc row end addr", rd_addr, 127);
    run_to(4, 4);
    chk("proc row 2 addr", rd_addr, 128);
    run_to(11, 8);
    chk("proc last addr", rd_addr, 167);
    run_to(12, 8);
    chk("proc last red", red, 8'hA7);
    chk("proc last green", green, 8'hA7);
    chk("proc last blue", blue, 8'hA7);

    // 3: select original
    wr(1'b0, 1'b1, 8'd1);
    run_to(4, 3);
    chk("orig first addr", rd_addr, 160120);
    chk("orig pixel left of window", red, 0);
    chk("orig blank_n visible", blank_n, 1);
    run_to(5, 3);
    chk("orig second addr", rd_addr, 160121);
    run_to(6, 3);
    chk("orig pixel red", red, 8'h79);
    chk("orig pixel green", green, 8'h79);
    chk("orig pixel blue", blue, 8'h79);
    run_to(17, 3);
    chk("blank_n in porch", blank_n, 0);
    run_to(18, 3);
    chk("hsync before pulse", hsync, 1);
    run_to(19, 3);
    chk("hsync in pulse", hsync, 0);
    run_to(0, 13);
    chk("vsync before pulse", vsync, 1);
    run_to(0, 14);
    chk("vsync in pulse", vsync, 0);

    // 4: both strobes, show_enb wins
    wr(1'b1, 1'b1, 8'd5);
    run_to(4, 3);
    chk("both strobes -> proc", rd_addr, 120);

    // 5: last write of the frame wins (disable)
    wr(1'b0, 1'b1, 8'd1);
    pix();
    wr(1'b1, 1'b0, 8'd0);
    run_to(4, 3);
    chk("idle first addr", rd_addr, 0);
    run_to(6, 3);
    chk("idle rd_addr stays 0", rd_addr, 0);
    chk("idle rgb", {red, green, blue}, 0);
    run_to(11, 8);
    chk("idle last addr", rd_addr, 0);

    // 6: reset while showing
    wr(1'b1, 1'b0, 8'd1);
    run_to(6, 5);
    chk("showing before reset", rd_addr, 138);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid reset hsync", hsync, 1);
    chk("mid reset vsync", vsync, 1);
    chk("mid reset blank_n", blank_n, 0);
    chk("mid reset rgb", {red, green, blue}, 0);
    chk("mid reset rd_addr", rd_addr, 0);
    chk("mid reset frame_start", frame_start, 0);
    rst = 1'b0;
    ticks = 0;
    fs_cnt = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      pix();
      fs_cnt += int'(frame_start);
    end
    chk("no frame_start before full frame", fs_cnt, 0);
    pix();
    chk("frame_start after full frame", frame_start, 1);
    run_to(5, 3);
    chk("mode idle after reset", rd_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
